// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and strobe active-low push buttons
// Optional auto-repeat is built when KEY_AUTOREPEAT_EN is defined.
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   KEY       in   raw active-low keys (0 = pressed)
//   BTN_LEVEL out  debounced state per key, 1 = pressed
//   BTN_PULSE out  one-cycle press strobe per key
module key_debounce #(
  parameter int NKEY = 3,
  parameter int TICK_DIV = 1000000,
  parameter int STABLE_N = 2
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE = 5
`endif
) (
  input  logic            CLOCK_50,
  input  logic            RST_N,
  input  logic [NKEY-1:0] KEY,
  output logic [NKEY-1:0] BTN_LEVEL,
  output logic [NKEY-1:0] BTN_PULSE
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_N + 1);
  logic [TW-1:0] tick_cnt;
  logic tick;
  logic [NKEY-1:0] sync_1, sync_2, pressed;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  assign pressed = ~sync_2;
  // Synchronisers reset to the released level so no false press follows reset.
  always_ff @(posedge CLOCK_50 or negedge RST_N)
    if (!RST_N) begin
      tick_cnt <= '0;
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      sync_1 <= KEY;
      sync_2 <= sync_1;
    end
  for (genvar i = 0; i < NKEY; i++) begin : g_key
    logic [SW-1:0] stab_cnt;
    logic level, pulse, differ, flip, rep_hit;
    assign differ = pressed[i] ^ level;
    // The last disagreeing sample of a run toggles the level on this tick.
    assign flip = tick & differ & (stab_cnt == SW'(STABLE_N - 1));
    always_ff @(posedge CLOCK_50 or negedge RST_N)
      if (!RST_N) begin
        stab_cnt <= '0;
        level <= 1'b0;
        pulse <= 1'b0;
      end else begin
        if (tick) stab_cnt <= (differ && !flip) ? stab_cnt + 1'b1 : '0;
        if (flip) level <= ~level;
        pulse <= (flip & ~level) | rep_hit;
      end
`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt;
    // After the first repeat, reload so later repeats come every REPEAT_RATE ticks.
    assign rep_hit = tick & level & ~flip & (rep_cnt == RW'(REPEAT_DELAY - 1));
    always_ff @(posedge CLOCK_50 or negedge RST_N)
      if (!RST_N) rep_cnt <= '0;
      else if (!level) rep_cnt <= '0;
      else if (tick) rep_cnt <= rep_hit ? RW'(REPEAT_DELAY - REPEAT_RATE) : rep_cnt + 1'b1;
`else
    assign rep_hit = 1'b0;
`endif
    assign BTN_LEVEL[i] = level;
    assign BTN_PULSE[i] = pulse;
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed self-checking bench for key_debounce
module tb_key_debounce;
  logic CLOCK_50 = 1'b0;
  logic RST_N = 1'b0;
  logic [2:0] KEY = 3'b111;
  logic [2:0] BTN_LEVEL, BTN_PULSE;
  logic [2:0] prev_pls = 3'b000;
  logic [2:0] seen, pv;
  int checks = 0, failures = 0, bb = 0;
  int first, drop, n_early, n_mid, rp, pc, n;
  int t [16];
`ifdef KEY_AUTOREPEAT_EN
  localparam int EXP_REP2 = 4;
  localparam int EXP_N6 = 8;
`else
  localparam int EXP_REP2 = 0;
  localparam int EXP_N6 = 1;
`endif
  always #5 CLOCK_50 = ~CLOCK_50;
  key_debounce #(
    .NKEY(3), .TICK_DIV(4), .STABLE_N(3)
`ifdef KEY_AUTOREPEAT_EN
    , .REPEAT_DELAY(4), .REPEAT_RATE(2)
`endif
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RST_N(RST_N),
    .KEY(KEY),
    .BTN_LEVEL(BTN_LEVEL),
    .BTN_PULSE(BTN_PULSE)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLOCK_50);
    #1;
    if (|(BTN_PULSE & prev_pls)) bb++;
    prev_pls = BTN_PULSE;
  endtask
  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask
  initial begin
    RST_N = 1'b0;
    KEY = 3'b000;
    seen = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      seen |= BTN_LEVEL | BTN_PULSE;
    end
    check("rst_outputs", 32'(seen), 0);
    RST_N = 1'b1;
    seen = '0;
    for (int c = 0; c < 7; c++) begin
      step();
      seen |= BTN_PULSE;
    end
    check("post_rst_no_pulse", 32'(seen), 0);
    KEY = 3'b111;
    for (int c = 0; c < 30; c++) begin
      step();
      seen |= BTN_PULSE | BTN_LEVEL;
    end
    check("short_press_rejected", 32'(seen), 0);
    KEY[0] = 1'b0;
    first = 0;
    n_early = 0;
    n_mid = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (BTN_PULSE[0]) begin
        if (first == 0) first = c;
        if (c <= 24) n_early++;
        else if (c <= 56) n_mid++;
      end
    end
    check("t2_press_latency", 32'(first >= 11 && first <= 16), 1);
    check("t2_one_press_pulse", 32'(n_early), 1);
    check("t2_repeats", 32'(n_mid), 32'(EXP_REP2));
    check("t2_level_held", 32'(BTN_LEVEL[0]), 1);
    KEY[0] = 1'b1;
    drop = 0;
    rp = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (!BTN_LEVEL[0] && drop == 0) drop = c;
      if (BTN_PULSE[0] && !BTN_LEVEL[0]) rp++;
    end
    check("t2_release_latency", 32'(drop >= 11 && drop <= 16), 1);
    check("t2_no_release_pulse", 32'(rp), 0);
    seen = '0;
    for (int c = 0; c < 48; c++) begin
      KEY[1] = ((c / 4) % 2) != 0;
      step();
      seen |= {1'b0, BTN_PULSE[1] | BTN_LEVEL[1], 1'b0};
    end
    check("t3_bounce_rejected", 32'(seen), 0);
    KEY[1] = 1'b0;
    n = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (BTN_PULSE[1]) n++;
    end
    check("t3_settled_pulse", 32'(n), 1);
    check("t3_settled_level", 32'(BTN_LEVEL[1]), 1);
    KEY[1] = 1'b1;
    idle(30);
    check("t3_released", 32'(BTN_LEVEL), 0);
    KEY = 3'b010;
    pc = 0;
    pv = '0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (BTN_PULSE != 3'b000) begin
        pc++;
        pv = BTN_PULSE;
      end
    end
    check("t4_pulse_cycles", 32'(pc), 1);
    check("t4_pulse_value", 32'(pv), 5);
    check("t4_level", 32'(BTN_LEVEL), 5);
    KEY = 3'b111;
    idle(30);
    KEY[0] = 1'b0;
    for (int c = 0; c < 30 && !BTN_LEVEL[0]; c++) step();
    check("t5_level_before", 32'(BTN_LEVEL[0]), 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("t5_async_level", 32'(BTN_LEVEL), 0);
    check("t5_async_pulse", 32'(BTN_PULSE), 0);
    idle(3);
    RST_N = 1'b1;
    n = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (BTN_PULSE[0]) n++;
    end
    check("t5_redetect", 32'(n), 1);
    KEY = 3'b111;
    idle(30);
    KEY[2] = 1'b0;
    n = 0;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (BTN_PULSE[2]) begin
        if (n < 16) t[n] = c;
        n++;
      end
    end
    check("t6_pulse_count", 32'(n), 32'(EXP_N6));
    check("t6_first_latency", 32'(t[0] >= 11 && t[0] <= 16), 1);
`ifdef KEY_AUTOREPEAT_EN
    check("t6_first_repeat_gap", 32'(t[1] - t[0]), 16);
    check("t6_repeat_gap", 32'(t[2] - t[1]), 8);
    check("t6_last_gap", 32'(t[7] - t[6]), 8);
`endif
    KEY = 3'b111;
    idle(30);
    check("t6_released", 32'(BTN_LEVEL), 0);
    check("no_back_to_back", 32'(bb), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
